gate_checker: RTL

Self-checking stimulus/response block for the basic two-input gate set. It drives the `a`/`b` inputs of a gate array through all four input combinations, waits a programmable settle time, and samples the six gate results. Each result is compared against the golden function, and the block reports pass/fail, the mismatch count and the first failing vector. It sits on the opposite side of the gate array's interface: the array consumes `a`/`b` and produces results; this block produces `a`/`b` and consumes the results.

---
 rtl/gate_checker.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/gate_checker.sv
// Stimulus/response checker for a two-input gate array: sweeps {a,b} through
// all four combinations, samples six gate results and tallies mismatches.
module gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter logic [5:0]  CHECK_MASK    = 6'b111111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic [5:0] gate_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] first_fail_vec,
    output logic [5:0] first_fail_bits
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [5:0] LAST_PASS   = 6'(PASSES - 1);

    state_t     r_state;
    state_t     w_state_nxt;

    logic [1:0] r_vec;
    logic [5:0] r_pass_cnt;
    logic [3:0] r_settle;
    logic       r_a;
    logic       r_b;
    logic       r_pass;
    logic [7:0] r_err;
    logic [1:0] r_ffv;
    logic [5:0] r_ffb;

    logic       w_a;
    logic       w_b;
    logic [5:0] w_expected;
    logic [5:0] w_mm;
    logic       w_fail;
    logic       w_last;

    // Golden response for the vector currently on the outputs.
    always_comb begin
        w_a        = r_vec[1];
        w_b        = r_vec[0];
        w_expected = {w_a & w_b, w_a | w_b, w_a ^ w_b, ~w_a, ~(w_a & w_b), ~(w_a ^ w_b)};
        w_mm       = (gate_in ^ w_expected) & CHECK_MASK;
        w_fail     = |w_mm;
        w_last     = (r_vec == 2'd3) && (r_pass_cnt == LAST_PASS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle == '0) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                w_state_nxt = w_last ? DONE : SETTLE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec      <= '0;
            r_pass_cnt <= '0;
            r_settle   <= '0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_ffv      <= '0;
            r_ffb      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_a <= 1'b0;
                    r_b <= 1'b0;
                    if (start) begin
                        r_vec      <= '0;
                        r_pass_cnt <= '0;
                        r_err      <= '0;
                        r_pass     <= 1'b0;
                        r_ffv      <= '0;
                        r_ffb      <= '0;
                        r_settle   <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (w_fail) begin
                        r_err <= r_err + 8'd1;
                        // Error count still zero means this is the run's first failure.
                        if (r_err == '0) begin
                            r_ffv <= r_vec;
                            r_ffb <= w_mm;
                        end
                    end
                    if (w_last) begin
                        r_a    <= 1'b0;
                        r_b    <= 1'b0;
                        r_pass <= (r_err == '0) && !w_fail;
                    end else begin
                        r_vec            <= r_vec + 2'd1;
                        {r_a, r_b}       <= r_vec + 2'd1;
                        r_settle         <= SETTLE_LOAD;
                        if (r_vec == 2'd3) begin
                            r_pass_cnt <= r_pass_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign a_out           = r_a;
    assign b_out           = r_b;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_fail_vec  = r_ffv;
    assign first_fail_bits = r_ffb;

endmodule
